// File: rtl/ysyx_201979054_reset_pkg.sv
// Shared types and constants for the reset generator: FSM states and
// bit positions inside the reset-cause register.
package ysyx_201979054_reset_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } rst_state_e;

   localparam int CAUSE_POR  = 0;
   localparam int CAUSE_BTN  = 1;
   localparam int CAUSE_SOFT = 2;
   localparam int CAUSE_WDT  = 3;

   localparam logic [3:0] CAUSE_POR_VAL = 4'(1) << CAUSE_POR;

endpackage

// File: rtl/ysyx_201979054_btn_filter.sv
// Reset-button front end: two-flop synchronizer, consecutive-high filter
// and an arm flag so a held button produces only one accept pulse.
module ysyx_201979054_btn_filter
   import ysyx_201979054_reset_pkg::*;
#(
   parameter int BTN_FILTER = 8
) (
   input  logic clk,
   input  logic arst,
   input  logic btn_rst_i,
   output logic accept_o
);

   localparam int FW = $clog2(BTN_FILTER + 1);
   localparam logic [FW-1:0] CNT_LAST = FW'(BTN_FILTER - 1);

   logic          sync1_q, sync2_q;
   logic          armed_q, armed_d;
   logic [FW-1:0] cnt_q, cnt_d;
   logic          accept;

   // The Nth consecutive high sample is itself the accepting sample.
   assign accept   = armed_q & sync2_q & (cnt_q == CNT_LAST);
   assign accept_o = accept;

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (!sync2_q) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end else if (accept) begin
         cnt_d   = '0;
         armed_d = 1'b0;
      end else if (armed_q) begin
         cnt_d = cnt_q + FW'(1);
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_rst_i;
         sync2_q <= sync1_q;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/ysyx_201979054_reset_gen.sv
// Source-side reset generator: stretches any reset trigger to a minimum
// width, then releases the stage resets one by one and records the cause.
module ysyx_201979054_reset_gen
   import ysyx_201979054_reset_pkg::*;
#(
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4,
   parameter int N_STAGES    = 3,
   parameter int BTN_FILTER  = 8,
   parameter int WDT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 btn_rst,
   input  logic                 soft_rst_req,
   input  logic                 wdt_en,
   input  logic                 wdt_kick,
   input  logic [WDT_WIDTH-1:0] wdt_limit,
   output logic [N_STAGES-1:0]  rst_out,
   output logic                 rst_done,
   output logic [3:0]           rst_cause
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int IW = $clog2(N_STAGES + 1);

   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] STAGE_LAST = IW'(N_STAGES - 1);

   rst_state_e           state_q, state_d;
   logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
   logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [N_STAGES-1:0]  rst_out_q, rst_out_d;
   logic                 rst_done_q, rst_done_d;
   logic [3:0]           cause_q, cause_d;
   logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;

   logic                 btn_accept;
   logic                 in_run;
   logic                 wdt_active;
   logic                 wdt_expire;
   logic                 trigger;
   logic                 hold_last;
   logic                 gap_last;
   logic                 last_stage;
   logic [3:0]           trig_cause;
   logic [N_STAGES-1:0]  stage_sel;

   ysyx_201979054_btn_filter #(
      .BTN_FILTER (BTN_FILTER)
   ) u_btn_filter (
      .clk       (clk),
      .arst      (arst),
      .btn_rst_i (btn_rst),
      .accept_o  (btn_accept)
   );

   // One-hot decode of the stage currently waiting to be released.
   generate
      for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage_sel
         assign stage_sel[gi] = (idx_q == IW'(gi));
      end
   endgenerate

   assign in_run     = (state_q == RUN);
   assign wdt_active = in_run & wdt_en & (wdt_limit != '0);
   // The >= keeps a lowered limit from letting the counter run away.
   assign wdt_expire = wdt_active & (wdt_cnt_q >= wdt_limit) & ~wdt_kick;
   assign trigger    = btn_accept | (in_run & (soft_rst_req | wdt_expire));
   assign hold_last  = (hold_cnt_q == HOLD_LAST);
   assign gap_last   = (gap_cnt_q == GAP_LAST);
   assign last_stage = (idx_q == STAGE_LAST);

   always_comb begin
      trig_cause             = '0;
      trig_cause[CAUSE_BTN]  = btn_accept;
      trig_cause[CAUSE_SOFT] = in_run & soft_rst_req;
      trig_cause[CAUSE_WDT]  = wdt_expire;
   end

   // State register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (trigger) begin
         state_d = HOLD;
      end else begin
         case (state_q)
            HOLD: begin
               if (hold_last) begin
                  state_d = (N_STAGES == 1) ? RUN : RELEASE;
               end
            end
            RELEASE: begin
               if (gap_last && last_stage) begin
                  state_d = RUN;
               end
            end
            RUN:     state_d = RUN;
            default: state_d = HOLD;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      idx_d      = idx_q;
      rst_out_d  = rst_out_q;
      rst_done_d = rst_done_q;
      cause_d    = cause_q;
      if (trigger) begin
         hold_cnt_d = '0;
         gap_cnt_d  = '0;
         idx_d      = IW'(1);
         rst_out_d  = '1;
         rst_done_d = 1'b0;
         cause_d    = trig_cause;
      end else begin
         case (state_q)
            HOLD: begin
               if (hold_last) begin
                  rst_out_d[0] = 1'b0;
                  gap_cnt_d    = '0;
                  idx_d        = IW'(1);
                  if (N_STAGES == 1) begin
                     rst_done_d = 1'b1;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + HW'(1);
               end
            end
            RELEASE: begin
               if (gap_last) begin
                  rst_out_d = rst_out_q & ~stage_sel;
                  gap_cnt_d = '0;
                  idx_d     = idx_q + IW'(1);
                  if (last_stage) begin
                     rst_done_d = 1'b1;
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + GW'(1);
               end
            end
            default: ;
         endcase
      end

      // Expiry also zeroes the counter; the reset it causes keeps it there.
      if (!wdt_active || wdt_kick || wdt_expire) begin
         wdt_cnt_d = '0;
      end else begin
         wdt_cnt_d = wdt_cnt_q + WDT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         idx_q      <= IW'(1);
         rst_out_q  <= '1;
         rst_done_q <= 1'b0;
         cause_q    <= CAUSE_POR_VAL;
         wdt_cnt_q  <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         idx_q      <= idx_d;
         rst_out_q  <= rst_out_d;
         rst_done_q <= rst_done_d;
         cause_q    <= cause_d;
         wdt_cnt_q  <= wdt_cnt_d;
      end
   end

   assign rst_out   = rst_out_q;
   assign rst_done  = rst_done_q;
   assign rst_cause = cause_q;

endmodule

// File: tb/tb_ysyx_201979054_reset_gen.sv
// Directed bench for the reset generator: power-on release table plus
// hand-written sequences for soft, watchdog, button and async reset cases.
module tb_ysyx_201979054_reset_gen;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        btn_rst = 1'b0;
   logic        soft_rst_req = 1'b0;
   logic        wdt_en = 1'b0;
   logic        wdt_kick = 1'b0;
   logic [15:0] wdt_limit = 16'd0;
   logic [2:0]  rst_out;
   logic        rst_done;
   logic [3:0]  rst_cause;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         edge_n;
      logic [2:0] out;
      logic       done;
      logic [3:0] cause;
   } vec_t;

   vec_t por_tab [8];

   always #5 clk = ~clk;

   ysyx_201979054_reset_gen #(
      .HOLD_CYCLES (16),
      .STAGE_GAP   (4),
      .N_STAGES    (3),
      .BTN_FILTER  (8),
      .WDT_WIDTH   (16)
   ) dut (
      .clk          (clk),
      .arst         (arst),
      .btn_rst      (btn_rst),
      .soft_rst_req (soft_rst_req),
      .wdt_en       (wdt_en),
      .wdt_kick     (wdt_kick),
      .wdt_limit    (wdt_limit),
      .rst_out      (rst_out),
      .rst_done     (rst_done),
      .rst_cause    (rst_cause)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [2:0] eo,
                        input logic ed, input logic [3:0] ec);
      tests++;
      if (rst_out !== eo || rst_done !== ed || rst_cause !== ec) begin
         fails++;
         $display("FAIL %s: got out=%b done=%b cause=%b, expected out=%b done=%b cause=%b",
                  name, rst_out, rst_done, rst_cause, eo, ed, ec);
      end else begin
         $display("ok   %s: out=%b done=%b cause=%b", name, rst_out, rst_done, rst_cause);
      end
   endtask

   task automatic wait_done(input string name);
      int i;
      i = 0;
      while (!rst_done && i < 200) begin
         tick();
         i++;
      end
      tests++;
      if (!rst_done) begin
         fails++;
         $display("FAIL %s: rst_done still %b after %0d cycles, expected 1", name, rst_done, i);
      end else begin
         $display("ok   %s: released after %0d cycles", name, i);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int e;
      int drops;

      por_tab[0] = '{1,  3'b111, 1'b0, 4'b0001};
      por_tab[1] = '{15, 3'b111, 1'b0, 4'b0001};
      por_tab[2] = '{16, 3'b110, 1'b0, 4'b0001};
      por_tab[3] = '{19, 3'b110, 1'b0, 4'b0001};
      por_tab[4] = '{20, 3'b100, 1'b0, 4'b0001};
      por_tab[5] = '{23, 3'b100, 1'b0, 4'b0001};
      por_tab[6] = '{24, 3'b000, 1'b1, 4'b0001};
      por_tab[7] = '{30, 3'b000, 1'b1, 4'b0001};

      // Power-on
      tick(3);
      check("reset_state", 3'b111, 1'b0, 4'b0001);
      arst = 1'b0;
      e = 0;
      for (int v = 0; v < 8; v++) begin
         while (e < por_tab[v].edge_n) begin
            tick();
            e++;
         end
         check($sformatf("por_edge%0d", por_tab[v].edge_n),
               por_tab[v].out, por_tab[v].done, por_tab[v].cause);
      end

      // Software reset
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      check("soft_trig", 3'b111, 1'b0, 4'b0100);
      tick(15);
      check("soft_hold15", 3'b111, 1'b0, 4'b0100);
      tick();
      check("soft_rel0", 3'b110, 1'b0, 4'b0100);
      tick(4);
      check("soft_rel1", 3'b100, 1'b0, 4'b0100);
      tick(4);
      check("soft_rel2", 3'b000, 1'b1, 4'b0100);

      // Watchdog expiry without kicks
      arst = 1'b1;
      tick();
      arst = 1'b0;
      tick(24);
      wdt_limit = 16'd10;
      wdt_en    = 1'b1;
      tick(10);
      check("wdt_pre_expiry", 3'b000, 1'b1, 4'b0001);
      tick();
      check("wdt_expiry", 3'b111, 1'b0, 4'b1000);
      wait_done("wdt_rerelease");

      // Regular kicks keep the system running
      drops = 0;
      for (int i = 0; i < 1000; i++) begin
         wdt_kick = (i % 8 == 7);
         tick();
         if (!rst_done) drops++;
      end
      wdt_kick = 1'b0;
      tests++;
      if (drops != 0) begin
         fails++;
         $display("FAIL wdt_kicked_1000: %0d cycles not in RUN, expected 0", drops);
      end else begin
         $display("ok   wdt_kicked_1000: no reset in 1000 cycles");
      end

      // Kick on the expiry cycle wins
      tick(10);
      check("wdt_at_limit", 3'b000, 1'b1, 4'b1000);
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      check("wdt_kick_wins", 3'b000, 1'b1, 4'b1000);
      wdt_en = 1'b0;
      tick(12);
      check("wdt_disabled", 3'b000, 1'b1, 4'b1000);

      // Soft request and watchdog expiry together
      wdt_en = 1'b1;
      tick(10);
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      check("soft_and_wdt", 3'b111, 1'b0, 4'b1100);
      wdt_en = 1'b0;
      wait_done("combo_rerelease");

      // Button: seven high samples are not enough
      btn_rst = 1'b1;
      tick(7);
      btn_rst = 1'b0;
      tick(12);
      check("btn_7_samples", 3'b000, 1'b1, 4'b1100);

      // Button: long press triggers exactly once
      btn_rst = 1'b1;
      tick(9);
      check("btn_pre_accept", 3'b000, 1'b1, 4'b1100);
      tick();
      check("btn_accept", 3'b111, 1'b0, 4'b0010);
      tick(24);
      check("btn_held_released", 3'b000, 1'b1, 4'b0010);
      tick(10);
      check("btn_held_no_retrig", 3'b000, 1'b1, 4'b0010);
      btn_rst = 1'b0;
      tick(4);
      btn_rst = 1'b1;
      tick(10);
      check("btn_rearmed", 3'b111, 1'b0, 4'b0010);
      btn_rst = 1'b0;
      wait_done("btn_rerelease");

      // Button accepted during RELEASE restarts HOLD
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      check("rel_soft_trig", 3'b111, 1'b0, 4'b0100);
      tick(8);
      btn_rst = 1'b1;
      tick(9);
      check("rel_stage0_free", 3'b110, 1'b0, 4'b0100);
      tick();
      btn_rst = 1'b0;
      check("rel_btn_restart", 3'b111, 1'b0, 4'b0010);
      tick(15);
      check("rel_hold15", 3'b111, 1'b0, 4'b0010);
      tick();
      check("rel_hold_done", 3'b110, 1'b0, 4'b0010);
      wait_done("rel_rerelease");

      // Asynchronous reset in the middle of RELEASE
      arst = 1'b1;
      tick();
      arst = 1'b0;
      tick(21);
      check("arst_pre", 3'b100, 1'b0, 4'b0001);
      #2;
      arst = 1'b1;
      #1;
      check("arst_async", 3'b111, 1'b0, 4'b0001);
      arst = 1'b0;
      tick(16);
      check("arst_restart_rel0", 3'b110, 1'b0, 4'b0001);
      tick(8);
      check("arst_restart_done", 3'b000, 1'b1, 4'b0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
